// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//   Multi-read-port register file with byte-masked synchronous writes and a
//   hardware clear sequencer that zeroes one entry per cycle after reset or
//   on request.
//
// Ports
//   clk           clock, all state updates on posedge
//   reset_n_i     asynchronous active-low reset (starts a clear sweep)
//   rs_addr_i     packed read addresses, port k at [k*addr_width_p +: addr_width_p]
//   rs_val_o      packed read data, port k at [k*data_width_p +: data_width_p]
//   rd_addr_i     write address, also read combinationally on rd_val_o
//   rd_val_o      current contents at rd_addr_i
//   wen_i         write enable (honoured only while idle)
//   wmask_i       byte-lane write mask, bit b covers bits [8b+7:8b]
//   write_data_i  write data
//   clear_i       request a full clear sweep (pulse is enough)
//   busy_o        high while the clear sweep runs
//
// Build option
//   REG_FILE_MP_BYPASS_EN  when defined, a read that hits the address being
//                          written in the same cycle returns the merged
//                          (post-write) word instead of the stored word.
// ---------------------------------------------------------------------------
module reg_file_mp #(
   parameter int addr_width_p = 6,
   parameter int data_width_p = 32,
   parameter int read_ports_p = 2,
   parameter int zero_reg_p   = 0
) (
   input  logic                                   clk,
   input  logic                                   reset_n_i,
   input  logic [read_ports_p*addr_width_p-1:0]   rs_addr_i,
   output logic [read_ports_p*data_width_p-1:0]   rs_val_o,
   input  logic [addr_width_p-1:0]                rd_addr_i,
   output logic [data_width_p-1:0]                rd_val_o,
   input  logic                                   wen_i,
   input  logic [data_width_p/8-1:0]              wmask_i,
   input  logic [data_width_p-1:0]                write_data_i,
   input  logic                                   clear_i,
   output logic                                   busy_o
);

   localparam int depth_c = 32'd1 << addr_width_p;
   localparam int bytes_c = data_width_p / 8;
   localparam bit zero_en_c = (zero_reg_p != 32'sd0);

   localparam logic [addr_width_p-1:0] ptr_zero_c = {addr_width_p{1'b0}};
   localparam logic [addr_width_p-1:0] ptr_last_c = {addr_width_p{1'b1}};
   localparam logic [addr_width_p-1:0] ptr_one_c  = addr_width_p'(32'd1);
   localparam logic [data_width_p-1:0] word_zero_c = {data_width_p{1'b0}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                     state_r;
   state_t                     state_nx_s;
   logic [addr_width_p-1:0]    clr_ptr_r;
   logic [addr_width_p-1:0]    clr_ptr_nx_s;

   logic                       busy_s;
   logic                       clr_we_s;
   logic                       wr_en_s;
   logic                       byp_en_s;
   logic [data_width_p-1:0]    wr_word_s;
   logic [read_ports_p*data_width_p-1:0] rs_val_s;
   logic [data_width_p-1:0]    rd_val_s;

   logic [data_width_p-1:0]    rf_r [depth_c];

   // Byte-lane merge: new bytes where the mask is set, old bytes elsewhere.
   function automatic logic [data_width_p-1:0] merge_bytes(
      input logic [data_width_p-1:0] old_word,
      input logic [data_width_p-1:0] new_word,
      input logic [bytes_c-1:0]      mask
   );
      logic [data_width_p-1:0] res;
      res = old_word;
      for (int b = 0; b < bytes_c; b++) begin
         if (mask[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_word[8*b +: 8];
         end
      end
      return res;
   endfunction

   // Read data selection; priority: sweep blanking, hardwired zero, bypass, array.
   function automatic logic [data_width_p-1:0] read_word(
      input logic                    busy,
      input logic [addr_width_p-1:0] addr,
      input logic [data_width_p-1:0] stored,
      input logic                    hit,
      input logic [data_width_p-1:0] merged
   );
      logic [data_width_p-1:0] res;
      if (busy) begin
         res = word_zero_c;
      end else if (zero_en_c && (addr == ptr_zero_c)) begin
         res = word_zero_c;
      end else if (hit) begin
         res = merged;
      end else begin
         res = stored;
      end
      return res;
   endfunction

   // State register: reset parks the FSM at the start of a clear sweep.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r   <= ST_CLEAR;
         clr_ptr_r <= ptr_zero_c;
      end else begin
         state_r   <= state_nx_s;
         clr_ptr_r <= clr_ptr_nx_s;
      end
   end

   // Next-state logic; clear_i always (re)starts the sweep from entry 0.
   always_comb begin
      state_nx_s   = state_r;
      clr_ptr_nx_s = clr_ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (clear_i) begin
               state_nx_s   = ST_CLEAR;
               clr_ptr_nx_s = ptr_zero_c;
            end else begin
               state_nx_s   = ST_IDLE;
               clr_ptr_nx_s = ptr_zero_c;
            end
         end
         ST_CLEAR: begin
            if (clear_i) begin
               state_nx_s   = ST_CLEAR;
               clr_ptr_nx_s = ptr_zero_c;
            end else if (clr_ptr_r == ptr_last_c) begin
               state_nx_s   = ST_IDLE;
               clr_ptr_nx_s = ptr_zero_c;
            end else begin
               state_nx_s   = ST_CLEAR;
               clr_ptr_nx_s = clr_ptr_r + ptr_one_c;
            end
         end
         default: begin
            state_nx_s   = ST_CLEAR;
            clr_ptr_nx_s = ptr_zero_c;
         end
      endcase
   end

   // Output decode: busy, sweep write strobe, user write strobe, bypass enable.
   always_comb begin
      busy_s   = 1'b1;
      clr_we_s = 1'b0;
      wr_en_s  = 1'b0;
      byp_en_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy_s   = 1'b0;
            clr_we_s = 1'b0;
            // clear_i wins over a same-cycle write; entry 0 may be read-only.
            if (wen_i && !clear_i && !(zero_en_c && (rd_addr_i == ptr_zero_c))) begin
               wr_en_s = 1'b1;
            end else begin
               wr_en_s = 1'b0;
            end
`ifdef REG_FILE_MP_BYPASS_EN
            byp_en_s = wen_i && !clear_i;
`else
            byp_en_s = 1'b0;
`endif
         end
         ST_CLEAR: begin
            busy_s   = 1'b1;
            clr_we_s = 1'b1;
            wr_en_s  = 1'b0;
            byp_en_s = 1'b0;
         end
         default: begin
            busy_s   = 1'b1;
            clr_we_s = 1'b0;
            wr_en_s  = 1'b0;
            byp_en_s = 1'b0;
         end
      endcase
   end

   // Merged write word, shared by the array write and the bypass path.
   always_comb begin
      wr_word_s = merge_bytes(rf_r[rd_addr_i], write_data_i, wmask_i);
   end

   // Storage array: no reset, contents are zeroed by the sweep instead.
   always_ff @(posedge clk) begin
      if (clr_we_s) begin
         rf_r[clr_ptr_r] <= word_zero_c;
      end else if (wr_en_s) begin
         rf_r[rd_addr_i] <= wr_word_s;
      end
   end

   // Combinational read ports (rs ports and the rd port).
   always_comb begin
      rs_val_s = {(read_ports_p*data_width_p){1'b0}};
      for (int k = 0; k < read_ports_p; k++) begin
         rs_val_s[k*data_width_p +: data_width_p] =
            read_word(busy_s,
                      rs_addr_i[k*addr_width_p +: addr_width_p],
                      rf_r[rs_addr_i[k*addr_width_p +: addr_width_p]],
                      byp_en_s && (rs_addr_i[k*addr_width_p +: addr_width_p] == rd_addr_i),
                      wr_word_s);
      end
      rd_val_s = read_word(busy_s, rd_addr_i, rf_r[rd_addr_i], byp_en_s, wr_word_s);
   end

   assign rs_val_o = rs_val_s;
   assign rd_val_o = rd_val_s;
   assign busy_o   = busy_s;

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
//   Two instances share one stimulus stream: dut0 with zero_reg_p=0 and dut1
//   with zero_reg_p=1. A behavioural model (busy countdown + plain arrays)
//   predicts every output each cycle; directed table rows and short
//   sequences add fixed expected values for the called-out corner cases.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int NP    = 2;
   localparam int DEPTH = 64;

   logic          clk;
   logic          reset_n;
   logic [AW-1:0] rs0_a;
   logic [AW-1:0] rs1_a;
   logic [NP*AW-1:0] rs_addr;
   logic [AW-1:0] rd_addr;
   logic          wen;
   logic [3:0]    wmask;
   logic [DW-1:0] wdata;
   logic          clear;

   logic [NP*DW-1:0] rs_val0, rs_val1;
   logic [DW-1:0]    rd_val0, rd_val1;
   logic             busy0, busy1;

   assign rs_addr = {rs1_a, rs0_a};

   reg_file_mp #(.addr_width_p(AW), .data_width_p(DW), .read_ports_p(NP), .zero_reg_p(0)) dut0 (
      .clk(clk), .reset_n_i(reset_n), .rs_addr_i(rs_addr), .rs_val_o(rs_val0),
      .rd_addr_i(rd_addr), .rd_val_o(rd_val0), .wen_i(wen), .wmask_i(wmask),
      .write_data_i(wdata), .clear_i(clear), .busy_o(busy0)
   );

   reg_file_mp #(.addr_width_p(AW), .data_width_p(DW), .read_ports_p(NP), .zero_reg_p(1)) dut1 (
      .clk(clk), .reset_n_i(reset_n), .rs_addr_i(rs_addr), .rs_val_o(rs_val1),
      .rd_addr_i(rd_addr), .rd_val_o(rd_val1), .wen_i(wen), .wmask_i(wmask),
      .write_data_i(wdata), .clear_i(clear), .busy_o(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] mem0 [DEPTH];
   logic [31:0] mem1 [DEPTH];
   int          busy_cnt;
   int          total;
   int          bad;

   typedef struct {
      logic        wen;
      logic [3:0]  mask;
      logic [5:0]  rd;
      logic [31:0] data;
      logic [5:0]  r0;
      logic [5:0]  r1;
      logic        chk_rd;
      logic [31:0] e0_rs0, e0_rs1, e0_rd;
      logic [31:0] e1_rs0, e1_rs1, e1_rd;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] m);
      logic [31:0] bm;
      bm = 32'd0;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) bm = bm | (32'h0000_00FF << (8*b));
      end
      return (old & ~bm) | (nw & bm);
   endfunction

   function automatic logic [31:0] exp_read(input bit z, input logic [5:0] a);
      logic [31:0] stored;
      stored = z ? mem1[a] : mem0[a];
      if (busy_cnt > 0) return 32'd0;
      if (z && (a == 6'd0)) return 32'd0;
`ifdef REG_FILE_MP_BYPASS_EN
      if (wen && !clear && (a == rd_addr)) return m_merge(stored, wdata, wmask);
`endif
      return stored;
   endfunction

   task automatic model_reset();
      busy_cnt = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
         mem0[i] = 32'd0;
         mem1[i] = 32'd0;
      end
   endtask

   task automatic model_update();
      if (!reset_n) return;
      if (busy_cnt > 0) begin
         if (clear) busy_cnt = DEPTH;
         else       busy_cnt = busy_cnt - 1;
      end else if (clear) begin
         model_reset();
      end else if (wen) begin
         mem0[rd_addr] = m_merge(mem0[rd_addr], wdata, wmask);
         if (rd_addr != 6'd0) mem1[rd_addr] = m_merge(mem1[rd_addr], wdata, wmask);
      end
   endtask

   task automatic model_check();
      logic [31:0] eb;
      eb = (busy_cnt > 0) ? 32'd1 : 32'd0;
      chk("m_busy_z0", {31'd0, busy0}, eb);
      chk("m_busy_z1", {31'd0, busy1}, eb);
      chk("m_rs0_z0", rs_val0[31:0],  exp_read(1'b0, rs0_a));
      chk("m_rs1_z0", rs_val0[63:32], exp_read(1'b0, rs1_a));
      chk("m_rd_z0",  rd_val0,        exp_read(1'b0, rd_addr));
      chk("m_rs0_z1", rs_val1[31:0],  exp_read(1'b1, rs0_a));
      chk("m_rs1_z1", rs_val1[63:32], exp_read(1'b1, rs1_a));
      chk("m_rd_z1",  rd_val1,        exp_read(1'b1, rd_addr));
   endtask

   task automatic half_a();
      @(negedge clk);
      model_check();
   endtask

   task automatic half_b();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic tick();
      half_a();
      half_b();
   endtask

   task automatic set_in(input logic w, input logic [3:0] m, input logic [5:0] rd,
                         input logic [31:0] d, input logic [5:0] r0, input logic [5:0] r1,
                         input logic c);
      wen = w; wmask = m; rd_addr = rd; wdata = d; rs0_a = r0; rs1_a = r1; clear = c;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Expect busy high for exactly 64 cycles, then low.
   task automatic expect_sweep(input string nm);
      for (int i = 0; i < DEPTH; i++) begin
         half_a();
         chk({nm, "_busy_hi"}, {31'd0, busy0 & busy1}, 32'd1);
         half_b();
      end
      half_a();
      chk({nm, "_busy_lo"}, {31'd0, busy0 | busy1}, 32'd0);
      half_b();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] byp_exp;
      total = 0;
      bad   = 0;
      busy_cnt = 0;
      reset_n = 1'b1;
      set_in(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 6'd0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         mem0[i] = 32'd0;
         mem1[i] = 32'd0;
      end

      // Power-on reset and full sweep
      #3;
      reset_n = 1'b0;
      model_reset();
      tick(); tick(); tick();
      reset_n = 1'b1;
      expect_sweep("por");
      for (int a = 0; a < DEPTH; a++) begin
         set_in(1'b0, 4'h0, 6'(a), 32'd0, 6'(a), 6'(DEPTH-1-a), 1'b0);
         half_a();
         chk("por_rs0", rs_val0[31:0], 32'd0);
         chk("por_rs1", rs_val0[63:32], 32'd0);
         half_b();
      end

      // Directed table (pre-edge expectations, no same-cycle read/write hits)
      vt[0] = '{1'b1, 4'hF, 6'd5, 32'hDEADBEEF, 6'd6, 6'd0, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      vt[1] = '{1'b1, 4'h2, 6'd5, 32'h00001200, 6'd6, 6'd6, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      vt[2] = '{1'b0, 4'h0, 6'd5, 32'h0, 6'd5, 6'd5, 1'b1,
                32'hDEAD12EF, 32'hDEAD12EF, 32'hDEAD12EF, 32'hDEAD12EF, 32'hDEAD12EF, 32'hDEAD12EF};
      vt[3] = '{1'b1, 4'hF, 6'd0, 32'hFFFFFFFF, 6'd1, 6'd1, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      vt[4] = '{1'b1, 4'hF, 6'd1, 32'hFFFFFFFF, 6'd0, 6'd0, 1'b0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
      vt[5] = '{1'b0, 4'h0, 6'd0, 32'h0, 6'd0, 6'd1, 1'b1,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0};
      vt[6] = '{1'b1, 4'hF, 6'd3, 32'h11111111, 6'd5, 6'd1, 1'b0,
                32'hDEAD12EF, 32'hFFFFFFFF, 32'h0, 32'hDEAD12EF, 32'hFFFFFFFF, 32'h0};
      vt[7] = '{1'b1, 4'h0, 6'd3, 32'h0, 6'd3, 6'd3, 1'b1,
                32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
      vt[8] = '{1'b0, 4'h0, 6'd3, 32'h0, 6'd3, 6'd2, 1'b1,
                32'h11111111, 32'h0, 32'h11111111, 32'h11111111, 32'h0, 32'h11111111};
      for (int i = 0; i < 9; i++) begin
         set_in(vt[i].wen, vt[i].mask, vt[i].rd, vt[i].data, vt[i].r0, vt[i].r1, 1'b0);
         half_a();
         chk($sformatf("tbl%0d_z0_rs0", i), rs_val0[31:0],  vt[i].e0_rs0);
         chk($sformatf("tbl%0d_z0_rs1", i), rs_val0[63:32], vt[i].e0_rs1);
         chk($sformatf("tbl%0d_z1_rs0", i), rs_val1[31:0],  vt[i].e1_rs0);
         chk($sformatf("tbl%0d_z1_rs1", i), rs_val1[63:32], vt[i].e1_rs1);
         if (vt[i].chk_rd) begin
            chk($sformatf("tbl%0d_z0_rd", i), rd_val0, vt[i].e0_rd);
            chk($sformatf("tbl%0d_z1_rd", i), rd_val1, vt[i].e1_rd);
         end
         half_b();
      end

      // Clear together with a write: the write is dropped, sweep blanks reads
      set_in(1'b1, 4'hF, 6'd4, 32'h22222222, 6'd3, 6'd4, 1'b1);
      half_a();
      chk("clr_pre_rs0", rs_val0[31:0],  32'h11111111);
      chk("clr_pre_rs1", rs_val0[63:32], 32'h0);
      half_b();
      set_in(1'b1, 4'hF, 6'd9, 32'hAAAAAAAA, 6'd3, 6'd9, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         half_a();
         chk("clr_busy_hi", {31'd0, busy0}, 32'd1);
         chk("clr_rs0_blank", rs_val0[31:0], 32'd0);
         half_b();
      end
      set_in(1'b0, 4'h0, 6'd4, 32'h0, 6'd3, 6'd9, 1'b0);
      half_a();
      chk("clr_busy_lo", {31'd0, busy0}, 32'd0);
      chk("clr_addr3", rs_val0[31:0],  32'd0);
      chk("clr_addr9", rs_val0[63:32], 32'd0);
      chk("clr_addr4", rd_val0,        32'd0);
      half_b();

      // Same-cycle write and read of the same address
      set_in(1'b1, 4'hF, 6'd7, 32'h12345678, 6'd0, 6'd0, 1'b0);
      tick();
      set_in(1'b1, 4'hF, 6'd7, 32'hCAFEF00D, 6'd7, 6'd7, 1'b0);
`ifdef REG_FILE_MP_BYPASS_EN
      byp_exp = 32'hCAFEF00D;
`else
      byp_exp = 32'h12345678;
`endif
      half_a();
      chk("same_rs0", rs_val0[31:0],  byp_exp);
      chk("same_rs1", rs_val0[63:32], byp_exp);
      chk("same_rd",  rd_val0,        byp_exp);
      half_b();
      set_in(1'b0, 4'h0, 6'd7, 32'h0, 6'd7, 6'd7, 1'b0);
      half_a();
      chk("after_rs0", rs_val0[31:0],  32'hCAFEF00D);
      chk("after_rs1", rs_val0[63:32], 32'hCAFEF00D);
      half_b();

      // Reset again at sweep cycle 20: sweep restarts from the second release
      do_reset();
      for (int i = 0; i < 20; i++) tick();
      do_reset();
      expect_sweep("rst2");

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         set_in(1'($urandom),
                4'($urandom),
                (i % 4 == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
                $urandom,
                (i % 5 == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
                6'($urandom_range(0, 7)),
                ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
